// File: rtl/vector_alu_pkg.sv
// Shared types for the pipelined vector ALU.
package vector_alu_pkg;
   typedef enum logic [2:0] {
      OP_PASS, OP_SUB, OP_MUL, OP_ADD, OP_SHL, OP_SRA, OP_MAC, OP_SRL
   } valu_op_e;
endpackage

// File: rtl/vector_alu_lane.sv
// One ALU lane: combinational result/sign from the S1 operands, plus the lane's MAC accumulator.
module vector_alu_lane
   import vector_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MUL_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  valu_op_e         op,
   input  logic             vcsub,
   input  logic             active,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             xfer,
   input  logic             acc_clr,
   output logic [WIDTH-1:0] res,
   output logic             neg
);
   localparam int SW = $clog2(WIDTH);

   logic [WIDTH-1:0] acc, diff, prod, acc_base, mac_sum;
   logic [SW-1:0]    shamt;
   logic             big, ovr, acc_we;

   assign diff     = a - b;
   assign neg      = diff[WIDTH-1];
   assign ovr      = vcsub & neg;
   assign big      = (b >= WIDTH'(WIDTH));
   assign shamt    = b[SW-1:0];
   assign prod     = WIDTH'(a[MUL_W-1:0]) * WIDTH'(b[MUL_W-1:0]);
   // A clear coincident with a MAC makes that MAC start from zero.
   assign acc_base = acc_clr ? '0 : acc;
   assign mac_sum  = acc_base + prod;
   assign acc_we   = xfer && active && !ovr && (op == OP_MAC);

   always_comb begin
      res = a;
      if (active && !ovr) begin
         unique case (op)
            OP_PASS: res = a;
            OP_SUB:  res = diff;
            OP_MUL:  res = prod;
            OP_ADD:  res = a + b;
            OP_SHL:  res = big ? '0 : a << shamt;
            OP_SRA:  res = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
            OP_MAC:  res = mac_sum;
            OP_SRL:  res = big ? '0 : a >> shamt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc <= '0;
      else if (acc_we)  acc <= mac_sum;
      else if (acc_clr) acc <= '0;
   end
endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage N-lane vector ALU with per-lane masking and valid/ready backpressure.
module vector_alu_pipe
   import vector_alu_pkg::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 32,
   parameter int MUL_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             in_op,
   input  logic                   in_vcsub,
   input  logic [LANES-1:0]       in_mask,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic                   acc_clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_neg,
   output logic                   busy
);
   logic [2:1]                  vld_pipe;
   logic                        adv1, adv2, xfer;
   valu_op_e                    op_q;
   logic                        vcsub_q;
   logic [LANES-1:0]            mask_q, neg;
   logic [LANES-1:0][WIDTH-1:0] a_q, b_q, res;

   assign adv2      = !vld_pipe[2] || out_ready;
   assign adv1      = !vld_pipe[1] || adv2;
   assign in_ready  = adv1;
   assign xfer      = vld_pipe[1] && adv2;
   assign out_valid = vld_pipe[2];
   assign busy      = |vld_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[1] <= 1'b0;
         op_q        <= OP_PASS;
         vcsub_q     <= 1'b0;
         mask_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
      end else if (adv1) begin
         vld_pipe[1] <= in_valid;
         if (in_valid) begin
            op_q    <= valu_op_e'(in_op);
            vcsub_q <= in_vcsub;
            mask_q  <= in_mask;
            a_q     <= in_a;
            b_q     <= in_b;
         end
      end
   end

   // S2 only loads on a real transfer so a stalled result stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[2] <= 1'b0;
         out_data    <= '0;
         out_neg     <= '0;
      end else if (adv2) begin
         vld_pipe[2] <= vld_pipe[1];
         if (vld_pipe[1]) begin
            out_data <= res;
            out_neg  <= neg;
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      vector_alu_lane #(.WIDTH(WIDTH), .MUL_W(MUL_W)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .op      (op_q),
         .vcsub   (vcsub_q),
         .active  (mask_q[l]),
         .a       (a_q[l]),
         .b       (b_q[l]),
         .xfer    (xfer),
         .acc_clr (acc_clr),
         .res     (res[l]),
         .neg     (neg[l])
      );
   end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Directed bench for vector_alu_pipe: handshake timing, vcsub, MAC/clear, masking, stalls, shifts, reset.
module tb_vector_alu_pipe;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_vcsub, acc_clr, out_valid, out_ready, busy;
   logic [2:0]   in_op;
   logic [3:0]   in_mask, out_neg;
   logic [127:0] in_a, in_b, out_data;

   int checks = 0;
   int failures = 0;

   vector_alu_pipe #(.LANES(4), .WIDTH(32), .MUL_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_vcsub(in_vcsub), .in_mask(in_mask), .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] v4(input logic [31:0] l3, l2, l1, l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one op, then let it reach S2; clr is applied on the S1->S2 transfer edge.
   task automatic do_op(input logic [2:0] op, input logic vc, input logic [3:0] m,
                        input logic [127:0] a, input logic [127:0] b, input logic clr);
      in_op = op; in_vcsub = vc; in_mask = m; in_a = a; in_b = b;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; acc_clr = clr;
      step();
      acc_clr = 1'b0;
   endtask

   initial begin
      int            sent, got;
      bit            hold;
      logic [131:0]  held;

      rst_n = 1'b0; in_valid = 0; in_op = 0; in_vcsub = 0; in_mask = 4'hf;
      in_a = '0; in_b = '0; acc_clr = 0; out_ready = 1;
      repeat (3) step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_neg", out_neg, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // 1: ADD latency
      in_op = 3'b011; in_a = v4(0, 0, 0, 5); in_b = v4(0, 0, 0, 7); in_valid = 1;
      #1;
      chk("t1_in_ready", in_ready, 1);
      step();
      in_valid = 0;
      chk("t1_valid_c1", out_valid, 0);
      chk("t1_busy_c1", busy, 1);
      step();
      chk("t1_valid_c2", out_valid, 1);
      chk("t1_data", out_data, v4(0, 0, 0, 12));
      chk("t1_neg", out_neg, 4'b0001);
      step();
      chk("t1_drained", out_valid, 0);

      // 2: conditional subtract
      do_op(3'b001, 1, 4'hf, v4(0, 0, 9, 3), v4(0, 0, 3, 9), 0);
      chk("t2_data", out_data, v4(0, 0, 6, 3));
      chk("t2_neg", out_neg, 4'b0001);

      // 3: MAC chain then clear coincident with MAC
      do_op(3'b110, 0, 4'hf, v4(2, 2, 2, 2), v4(3, 3, 3, 3), 0);
      chk("t3_mac1", out_data, v4(6, 6, 6, 6));
      chk("t3_mac1_neg", out_neg, 4'b1111);
      do_op(3'b110, 0, 4'hf, v4(2, 2, 2, 2), v4(3, 3, 3, 3), 0);
      chk("t3_mac2", out_data, v4(12, 12, 12, 12));
      do_op(3'b110, 0, 4'hf, v4(2, 2, 2, 2), v4(3, 3, 3, 3), 0);
      chk("t3_mac3", out_data, v4(18, 18, 18, 18));
      do_op(3'b110, 0, 4'hf, v4(2, 2, 2, 2), v4(3, 3, 3, 3), 1);
      chk("t3_mac_clr", out_data, v4(6, 6, 6, 6));

      // acc_clr alone, then masked MAC
      acc_clr = 1; step(); acc_clr = 0;
      do_op(3'b110, 0, 4'hf, v4(2, 2, 2, 2), v4(0, 0, 0, 0), 0);
      chk("t4_after_clr", out_data, v4(0, 0, 0, 0));
      do_op(3'b110, 0, 4'b0101, v4(2, 2, 2, 2), v4(3, 3, 3, 3), 0);
      chk("t4_masked", out_data, v4(2, 6, 2, 6));
      do_op(3'b110, 0, 4'hf, v4(2, 2, 2, 2), v4(0, 0, 0, 0), 0);
      chk("t4_acc_probe", out_data, v4(0, 6, 0, 6));
      do_op(3'b010, 0, 4'hf, v4(32'h1_0003, 0, 32'hffff, 7), v4(32'h2_0005, 0, 32'hffff, 6), 0);
      chk("t4_mul", out_data, v4(15, 0, 32'hfffe_0001, 42));
      step(); step();

      // 5: stream of 8 ADDs with a 5-cycle out_ready stall
      in_op = 3'b011; in_vcsub = 0; in_mask = 4'hf;
      sent = 0; got = 0; hold = 0; held = '0;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 8);
         in_valid  = (sent < 8);
         in_a = v4(0, 0, 0, 100 + sent);
         in_b = v4(0, 0, 0, sent);
         #1;
         chk("t5_in_ready", in_ready, ((sent - got) < 2) || out_ready);
         if (hold) chk("t5_stable", {out_valid, out_neg, out_data[127:1]}, {1'b1, held[131:1]});
         hold = out_valid && !out_ready;
         held = {out_neg, out_data};
         if (out_valid && out_ready) begin
            chk("t5_result", out_data, v4(0, 0, 0, 100 + 2 * got));
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid = 0; out_ready = 1;
      chk("t5_all_received", got, 8);
      chk("t5_all_sent", sent, 8);
      step();
      chk("t5_no_dup", out_valid, 0);

      // 6: shift boundaries
      do_op(3'b111, 0, 4'hf, v4(0, 0, 32'hf000_0000, 32'hffff_ffff), v4(0, 0, 4, 32), 0);
      chk("t6_srl", out_data, v4(0, 0, 32'h0f00_0000, 0));
      do_op(3'b100, 0, 4'hf, v4(0, 0, 1, 1), v4(0, 0, 31, 32), 0);
      chk("t6_shl", out_data, v4(0, 0, 32'h8000_0000, 0));
      do_op(3'b101, 0, 4'hf, v4(0, 32'h7fff_ffff, 32'h8000_0000, 32'h8000_0000), v4(0, 33, 4, 40), 0);
      chk("t6_sra", out_data, v4(0, 0, 32'hf800_0000, 32'hffff_ffff));
      step(); step();

      // reset with two ops in flight
      in_op = 3'b011; in_a = v4(1, 1, 1, 1); in_b = v4(1, 1, 1, 1); in_valid = 1; out_ready = 0;
      step(); step();
      in_valid = 0;
      chk("t6_full_in_ready", in_ready, 0);
      rst_n = 0;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_data", out_data, 0);
      step();
      rst_n = 1; out_ready = 1;
      #1;
      chk("t6_rel_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_ghost", out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
